// File: rtl/mips_core_pkg.sv
// mips_core_pkg: shared types for the memory port arbiter.
// Holds the arbiter state encoding, the requester identity and the
// line-offset helper used to derive line base addresses.
package mips_core_pkg;

    typedef enum logic [2:0] {IDLE, I_RADDR, I_RDATA, D_RADDR, D_RDATA, D_WR} MemArbState;

    typedef enum logic {ICACHE, DCACHE} MemRequester;

    // Byte-offset bits of a line: word index bits plus the two byte bits.
    function automatic int line_offset_bits(input int words);
        return $clog2(words) + 2;
    endfunction

    localparam int LINE_WORDS_DEF   = 4;
    localparam int LINE_OFFSET_BITS = line_offset_bits(LINE_WORDS_DEF);

endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select: combinational picker between i-cache and d-cache requests.
// Ports: i_ic_req, i_dc_req (request levels), i_last_grant (round-robin only),
//        o_valid (some request pending), o_pick (winning requester).
// Macro MEM_ARB_ROUND_ROBIN_EN: ties go to the requester not granted last;
// otherwise the d-cache always wins a tie.
module mem_arb_select
    import mips_core_pkg::*;
(
    input  logic        i_ic_req,
    input  logic        i_dc_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  MemRequester i_last_grant,
`endif
    output logic        o_valid,
    output MemRequester o_pick
);

    always_comb begin
        o_valid = i_ic_req || i_dc_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        o_pick  = (i_ic_req && i_dc_req) ? ((i_last_grant == ICACHE) ? DCACHE : ICACHE)
                                         : (i_dc_req ? DCACHE : ICACHE);
`else
        o_pick  = i_dc_req ? DCACHE : ICACHE;
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between i-cache refills and
// d-cache refills/write-backs, one line burst at a time.
// Ports: ic_* (i-cache miss engine), dc_* (d-cache miss engine),
//        mem_* (external memory port), clk, rst (async, active high).
// Macro MEM_ARB_ROUND_ROBIN_EN: round-robin tie-break with a last_grant
// register; undefined, the d-cache wins every tie.
module mem_port_arbiter
    import mips_core_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ic_req,
    input  logic [ADDR_WIDTH-1:0] ic_addr,
    output logic                  ic_gnt,
    output logic                  ic_rvalid,
    output logic [DATA_WIDTH-1:0] ic_rdata,
    output logic                  ic_done,
    input  logic                  dc_req,
    input  logic                  dc_we,
    input  logic [ADDR_WIDTH-1:0] dc_addr,
    input  logic [DATA_WIDTH-1:0] dc_wdata,
    output logic                  dc_gnt,
    output logic                  dc_wnext,
    output logic                  dc_rvalid,
    output logic [DATA_WIDTH-1:0] dc_rdata,
    output logic                  dc_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int OFF = line_offset_bits(LINE_WORDS);
    localparam int CW  = OFF - 2;

    MemArbState            r_state;
    MemArbState            w_next;
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic                  w_pick_valid;
    MemRequester           w_pick;
    logic                  w_last;
    logic                  w_unused;

    // Line offset bits of the request addresses are dropped by design.
    assign w_unused = ^{ic_addr[OFF-1:0], dc_addr[OFF-1:0]};
    assign w_last   = (r_cnt == CW'(LINE_WORDS - 1));

`ifdef MEM_ARB_ROUND_ROBIN_EN
    MemRequester r_last_grant;

    mem_arb_select u_select (
        .i_ic_req     (ic_req),
        .i_dc_req     (dc_req),
        .i_last_grant (r_last_grant),
        .o_valid      (w_pick_valid),
        .o_pick       (w_pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last_grant <= ICACHE;
        else if (ic_gnt || dc_gnt)
            r_last_grant <= dc_gnt ? DCACHE : ICACHE;
    end
`else
    mem_arb_select u_select (
        .i_ic_req (ic_req),
        .i_dc_req (dc_req),
        .o_valid  (w_pick_valid),
        .o_pick   (w_pick)
    );
`endif

    always_comb begin
        w_next    = r_state;
        ic_gnt    = 1'b0;
        dc_gnt    = 1'b0;
        ic_rvalid = 1'b0;
        ic_rdata  = '0;
        ic_done   = 1'b0;
        dc_wnext  = 1'b0;
        dc_rvalid = 1'b0;
        dc_rdata  = '0;
        dc_done   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            IDLE: begin
                // Grants are combinational, so gate them while reset holds the FSM.
                ic_gnt = w_pick_valid && !rst && (w_pick == ICACHE);
                dc_gnt = w_pick_valid && !rst && (w_pick == DCACHE);
                w_next = ic_gnt ? I_RADDR : dc_gnt ? (dc_we ? D_WR : D_RADDR) : IDLE;
            end
            I_RADDR, D_RADDR: begin
                mem_req  = 1'b1;
                mem_addr = r_base;
                w_next   = !mem_ready ? r_state : (r_state == I_RADDR) ? I_RDATA : D_RDATA;
            end
            I_RDATA: begin
                ic_rvalid = mem_rvalid;
                ic_rdata  = mem_rvalid ? mem_rdata : '0;
                ic_done   = mem_rvalid && w_last;
                w_next    = ic_done ? IDLE : r_state;
            end
            D_RDATA: begin
                dc_rvalid = mem_rvalid;
                dc_rdata  = mem_rvalid ? mem_rdata : '0;
                dc_done   = mem_rvalid && w_last;
                w_next    = dc_done ? IDLE : r_state;
            end
            D_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_base[ADDR_WIDTH-1:OFF], r_cnt, 2'b00};
                mem_wdata = dc_wdata;
                dc_wnext  = mem_ready;
                dc_done   = mem_ready && w_last;
                w_next    = dc_done ? IDLE : r_state;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_base  <= '0;
        end else begin
            r_state <= w_next;
            if (ic_gnt)
                r_base <= {ic_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
            else if (dc_gnt)
                r_base <= {dc_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
            // Counter wraps to zero naturally after the last beat.
            if (r_state == I_RADDR || r_state == D_RADDR)
                r_cnt <= '0;
            else if (ic_rvalid || dc_rvalid || dc_wnext)
                r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req, ic_gnt, ic_rvalid, ic_done;
    logic [31:0] ic_addr, ic_rdata;
    logic        dc_req, dc_we, dc_gnt, dc_wnext, dc_rvalid, dc_done;
    logic [31:0] dc_addr, dc_wdata, dc_rdata;
    logic        mem_req, mem_we, mem_ready, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } ev_t;

    ev_t q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    mem_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .ic_req     (ic_req),
        .ic_addr    (ic_addr),
        .ic_gnt     (ic_gnt),
        .ic_rvalid  (ic_rvalid),
        .ic_rdata   (ic_rdata),
        .ic_done    (ic_done),
        .dc_req     (dc_req),
        .dc_we      (dc_we),
        .dc_addr    (dc_addr),
        .dc_wdata   (dc_wdata),
        .dc_gnt     (dc_gnt),
        .dc_wnext   (dc_wnext),
        .dc_rvalid  (dc_rvalid),
        .dc_rdata   (dc_rdata),
        .dc_done    (dc_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input string tag, input logic [31:0] val);
        ev_t e;
        e.tag = tag;
        e.val = val;
        q.push_back(e);
    endtask

    task automatic observe(input string tag, input logic [31:0] val);
        ev_t e;
        n_cmp++;
        if (q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: unexpected event %h, nothing queued", tag, val);
        end else begin
            e = q.pop_front();
            if (e.tag != tag || e.val !== val) begin
                n_bad++;
                $display("FAIL %s: got %s %h, want %s %h", tag, tag, val, e.tag, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ic_gnt) observe("IGNT", 32'h0);
            if (dc_gnt) observe("DGNT", 32'h0);
            if (mem_req && !mem_we && mem_ready) observe("MADDR", mem_addr);
            if (mem_req && mem_we && mem_ready) begin
                observe("MWR", mem_addr);
                observe("MWD", mem_wdata);
            end
            if (dc_wnext)  observe("WNEXT", 32'h0);
            if (ic_rvalid) observe("IRD", ic_rdata);
            if (ic_done)   observe("IDONE", 32'h0);
            if (dc_rvalid) observe("DRD", dc_rdata);
            if (dc_done)   observe("DDONE", 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Owner's req must already be high; grant is expected in the current IDLE cycle.
    task automatic do_read(input bit is_i, input logic [31:0] addr, input logic [31:0] dbase);
        string p;
        p = is_i ? "I" : "D";
        expect_ev({p, "GNT"}, 32'h0);
        expect_ev("MADDR", addr & 32'hFFFF_FFF0);
        for (int k = 0; k < 4; k++) begin
            expect_ev({p, "RD"}, dbase + 32'(k));
            if (k == 3) expect_ev({p, "DONE"}, 32'h0);
        end
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = dbase + 32'(k);
            tick();
        end
        mem_rvalid = 1'b0;
        if (is_i) ic_req = 1'b0;
        else      dc_req = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] wbase, input int stall_beat);
        logic [31:0] base;
        base = addr & 32'hFFFF_FFF0;
        expect_ev("DGNT", 32'h0);
        for (int k = 0; k < 4; k++) begin
            expect_ev("MWR", base + 32'(4 * k));
            expect_ev("MWD", wbase + 32'(k));
            expect_ev("WNEXT", 32'h0);
            if (k == 3) expect_ev("DDONE", 32'h0);
        end
        dc_req   = 1'b1;
        dc_we    = 1'b1;
        dc_addr  = addr;
        dc_wdata = wbase;
        tick();
        for (int k = 0; k < 4; k++) begin
            dc_wdata = wbase + 32'(k);
            if (k == stall_beat) begin
                mem_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_addr", mem_addr, base + 32'(4 * k));
                    check("stall_wdata", mem_wdata, wbase + 32'(k));
                    check("stall_wnext", {31'b0, dc_wnext}, 32'h0);
                    @(posedge clk);
                    #1;
                end
                mem_ready = 1'b1;
            end
            tick();
        end
        dc_req = 1'b0;
        dc_we  = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        ic_req     = 1'b1;
        dc_req     = 1'b1;
        ic_addr    = '0;
        dc_addr    = '0;
        dc_we      = 1'b0;
        dc_wdata   = '0;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55;
        #2;
        check("rst_ic_gnt", {31'b0, ic_gnt}, 32'h0);
        check("rst_dc_gnt", {31'b0, dc_gnt}, 32'h0);
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_ic_rvalid", {31'b0, ic_rvalid}, 32'h0);
        check("rst_dc_rvalid", {31'b0, dc_rvalid}, 32'h0);
        check("rst_dones", {30'b0, ic_done, dc_done}, 32'h0);
        check("rst_wnext", {31'b0, dc_wnext}, 32'h0);
        ic_req     = 1'b0;
        dc_req     = 1'b0;
        mem_rvalid = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        ic_req  = 1'b1;
        ic_addr = 32'h0000_104C;
        do_read(1'b1, 32'h0000_104C, 32'hA0);

        do_write(32'h0000_2000, 32'hD000_0000, 4);
        do_write(32'h0000_3018, 32'hE000_0000, 1);

        rst = 1'b1;
        tick();
        rst     = 1'b0;
        ic_req  = 1'b1;
        ic_addr = 32'h0000_5004;
        dc_req  = 1'b1;
        dc_we   = 1'b0;
        dc_addr = 32'h0000_4008;
        do_read(1'b0, 32'h0000_4008, 32'hB0);
        dc_req  = 1'b1;
        dc_addr = 32'h0000_4104;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        do_read(1'b1, 32'h0000_5004, 32'hC0);
        do_read(1'b0, 32'h0000_4104, 32'hD0);
`else
        do_read(1'b0, 32'h0000_4104, 32'hD0);
        do_read(1'b1, 32'h0000_5004, 32'hC0);
`endif

        ic_req  = 1'b1;
        ic_addr = 32'h0000_6008;
        expect_ev("IGNT", 32'h0);
        expect_ev("MADDR", 32'h0000_6000);
        expect_ev("IRD", 32'hE0);
        expect_ev("IRD", 32'hE1);
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hE0 + 32'(k);
            tick();
        end
        mem_rdata = 32'hE2;
        rst       = 1'b1;
        #1;
        check("abort_ic_rvalid", {31'b0, ic_rvalid}, 32'h0);
        check("abort_ic_rdata", ic_rdata, 32'h0);
        check("abort_ic_done", {31'b0, ic_done}, 32'h0);
        check("abort_ic_gnt", {31'b0, ic_gnt}, 32'h0);
        check("abort_mem_req", {31'b0, mem_req}, 32'h0);
        tick();
        mem_rvalid = 1'b0;
        rst        = 1'b0;
        do_read(1'b1, 32'h0000_6008, 32'hF0);

        mem_rvalid = 1'b1;
        mem_rdata  = 32'h77;
        @(negedge clk);
        check("stray_ic_rvalid", {31'b0, ic_rvalid}, 32'h0);
        check("stray_dc_rvalid", {31'b0, dc_rvalid}, 32'h0);
        tick();
        tick();
        mem_rvalid = 1'b0;
        tick();
        tick();

        while (q.size() > 0) begin
            ev_t e;
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_%s: never seen, want %h", e.tag, e.val);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between i-cache refills and d-cache refills/write-backs; one line-sized burst transaction at a time.
- Sits between both cache miss engines and the memory interface.
- Sequences each burst: address phase, beat counting, done signalling.

Parameters:
- ADDR_WIDTH, 32, byte address width (matches `ADDR_WIDTH).
- DATA_WIDTH, 32, word width (matches `DATA_WIDTH).
- LINE_WORDS, 4, words per burst; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ic_req  in  1  i-cache refill request (level).
- ic_addr  in  ADDR_WIDTH  i-cache miss address.
- ic_gnt  out  1  one-cycle pulse when i-cache transaction starts.
- ic_rvalid  out  1  refill beat valid.
- ic_rdata  out  DATA_WIDTH  refill beat data.
- ic_done  out  1  pulse with last i-cache beat.
- dc_req  in  1  d-cache request (level).
- dc_we  in  1  1 = write-back line, 0 = refill.
- dc_addr  in  ADDR_WIDTH  d-cache line address.
- dc_wdata  in  DATA_WIDTH  current write-back word.
- dc_gnt  out  1  one-cycle pulse when d-cache transaction starts.
- dc_wnext  out  1  pulse: dc_wdata consumed; present the next word.
- dc_rvalid  out  1  refill beat valid.
- dc_rdata  out  DATA_WIDTH  refill beat data.
- dc_done  out  1  pulse with last d-cache beat.
- mem_req  out  1  memory request valid.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_WIDTH  memory word address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_ready  in  1  memory accepts current request or write beat.
- mem_rvalid  in  1  read beat returned, in order.
- mem_rdata  in  DATA_WIDTH  read beat data.

Behaviour:
- Reset (async, any state): state=IDLE, beat counter=0, last_grant=ICACHE, latched address=0. All outputs 0. An aborted transaction produces no done pulse.
- Line base address = request address with the low log2(LINE_WORDS)+2 bits cleared. It is latched on the grant edge.
- States: IDLE, I_RADDR, I_RDATA, D_RADDR, D_RDATA, D_WR.
- IDLE:
  - ic_req alone -> I_RADDR.
  - dc_req alone -> D_RADDR if dc_we=0, D_WR if dc_we=1.
  - Both high: arbitration as in Optional Feature.
  - The gnt pulse is combinational in the IDLE cycle in which the transition is taken.
  - dc_we is sampled only at grant.
- x_RADDR: mem_req=1, mem_we=0, mem_addr=line base. On mem_ready -> x_RDATA with counter=0.
- x_RDATA:
  - mem_req=0.
  - Each mem_rvalid is forwarded combinationally to the owner's rvalid/rdata (zero latency), and counter increments.
  - The beat where counter==LINE_WORDS-1 also pulses done; counter wraps to 0 and state -> IDLE.
- D_WR:
  - mem_req=1, mem_we=1, mem_addr=line base + counter*4, mem_wdata=dc_wdata.
  - On mem_ready: dc_wnext pulses and counter increments.
  - On the last beat, dc_done pulses together with dc_wnext, then -> IDLE.
- Requesters hold req high until done and must have req low on the edge after done. Any req still high in IDLE starts a new transaction.
- mem_rvalid outside x_RDATA is ignored.
- The non-owner's rvalid, done, wnext and gnt stay 0.
- Minimum read latency: 1 address cycle + LINE_WORDS rvalid cycles.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests, grant the requester not in last_grant. last_grant updates at every grant. After reset d-cache wins the first tie.
- Undefined: d-cache always wins ties. last_grant register is absent.

Decomposition:
- mips_core_pkg gains:
  - enum MemArbState {IDLE, I_RADDR, I_RDATA, D_RADDR, D_RDATA, D_WR}.
  - enum MemRequester {ICACHE, DCACHE}.
  - localparam LINE_OFFSET_BITS = log2(LINE_WORDS)+2.
- One sub-module, mem_arb_select: combinational picker over ic_req, dc_req and last_grant. It contains the macro-guarded logic.

Test Plan:
- ic_req, ic_addr=0x0000_104C alone -> ic_gnt same cycle; mem_addr=0x0000_1040, mem_we=0. Four rvalid beats 0xA0..0xA3 appear on ic_rdata; ic_done coincides with 0xA3.
- dc_req, dc_we=1, dc_addr=0x2000, mem_ready held 1 -> mem_addr 0x2000, 0x2004, 0x2008, 0x200C on consecutive cycles. Four dc_wnext pulses; dc_done with the fourth.
- Both requests from reset, round-robin on -> DCACHE served first, ICACHE next. With the macro off and dc_req reasserted, DCACHE wins twice.
- mem_ready low 3 cycles in D_WR -> mem_addr and mem_wdata are held, no dc_wnext, counter unchanged.
- rst asserted mid-I_RDATA after 2 beats -> outputs 0 immediately, no ic_done. After release, a new ic_req restarts at beat 0.
- Stray mem_rvalid in IDLE -> no rvalid on either cache side.
